// File: rtl/capture_wb_buffer.sv
// Posted-write buffer between the capture sniffer (Wishbone slave side) and
// sample RAM port A (Wishbone master side), with ring address translation.
module capture_wb_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned RING_BYTES      = 16384,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_data_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_stb_i,
    output logic        s_stall_o,
    output logic        s_ack_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_stb_o,
    input  logic        m_stall_i,
    input  logic        m_ack_i,
    output logic [4:0]  level_o,
    output logic        idle_o,
    output logic [15:0] wraps_o,
    output logic        read_seen_o
);
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned ENTRY_W   = 68;
    localparam logic [4:0]  DEPTH_L   = 5'(DEPTH);
    localparam logic [1:0]  MAX_L     = 2'(MAX_OUTSTANDING);
    localparam logic [31:0] RING_MASK = 32'(RING_BYTES - 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [4:0]         count;
    logic [1:0]         outstanding;
    logic               ack_q;
    logic [31:0]        prev_off;
    logic [15:0]        wraps;
    logic               read_seen;

    logic               full;
    logic               accept;
    logic               push;
    logic               pop;
    logic               ack_valid;
    logic [31:0]        offset;
    logic [ENTRY_W-1:0] head;

    // Stall is based on registered occupancy only, so a same-cycle pop never
    // opens the slave side; this keeps s_stall_o free of downstream paths.
    assign full      = (count == DEPTH_L);
    assign s_stall_o = full & ~rst_i;
    assign s_ack_o   = ack_q & ~rst_i;
    assign accept    = s_stb_i & ~s_stall_o;
    assign push      = accept & s_we_i & ~rst_i;
    assign offset    = s_addr_i & RING_MASK;

    assign head      = mem[rd_ptr];
    assign m_stb_o   = ~rst_i & (count != 5'd0) & (outstanding < MAX_L);
    assign m_we_o    = m_stb_o;
    assign {m_addr_o, m_data_o, m_sel_o} = head;
    assign pop       = m_stb_o & ~m_stall_i;
    // Acks with nothing in flight are spurious and must not underflow.
    assign ack_valid = m_ack_i & (outstanding != 2'd0);

    assign level_o     = count;
    assign idle_o      = (count == 5'd0) & (outstanding == 2'd0);
    assign wraps_o     = wraps;
    assign read_seen_o = read_seen;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {BASE_ADDR + offset, s_data_i, s_sel_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= 5'd0;
            outstanding <= 2'd0;
            ack_q       <= 1'b0;
            prev_off    <= 32'd0;
            wraps       <= 16'd0;
            read_seen   <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept && !s_we_i) begin
                read_seen <= 1'b1;
            end

            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                prev_off <= offset;
                // A lower offset than the previous push means the ring wrapped.
                if ((offset < prev_off) && (wraps != 16'hFFFF)) begin
                    wraps <= wraps + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase

            case ({pop, ack_valid})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_wb_buffer.sv
// Scoreboard bench for capture_wb_buffer: expected downstream writes are queued
// at upstream acceptance and compared as the master side issues them.
`timescale 1ns/1ps
module tb_capture_wb_buffer;
    localparam logic [31:0] RING_MASK = 32'h0000_3FFF;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] s_addr_i = '0;
    logic [31:0] s_data_i = '0;
    logic [3:0]  s_sel_i = '0;
    logic        s_we_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic        s_stall_o;
    logic        s_ack_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_stb_o;
    logic        m_stall_i;
    logic        m_ack_i;
    logic [4:0]  level_o;
    logic        idle_o;
    logic [15:0] wraps_o;
    logic        read_seen_o;

    capture_wb_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_sel_i(s_sel_i),
        .s_we_i(s_we_i), .s_stb_i(s_stb_i), .s_stall_o(s_stall_o), .s_ack_o(s_ack_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_stall_i(m_stall_i), .m_ack_i(m_ack_i),
        .level_o(level_o), .idle_o(idle_o), .wraps_o(wraps_o), .read_seen_o(read_seen_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [67:0] exp_q[$];
    int          pend = 0;
    int          strobes = 0;
    bit          auto_ack = 0;
    bit          stray_ack = 0;
    bit          rand_stall = 0;
    bit          stall_force = 0;
    bit          flush = 0;
    logic [31:0] m_prev_off = '0;
    logic [15:0] m_wraps = '0;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Downstream responder and write monitor.
    initial begin
        bit ack;
        m_stall_i = 1'b0;
        m_ack_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (m_stb_o && !m_stall_i) begin
                strobes++;
                pend++;
                if (exp_q.size() == 0) check("unexpected_write", 68'd1, 68'd0);
                else check("write_order", {m_addr_o, m_data_o, m_sel_o}, exp_q.pop_front());
            end
            @(posedge clk_i);
            #1;
            if (flush) begin
                pend  = 0;
                flush = 0;
            end
            ack = (auto_ack && pend > 0) || stray_ack;
            if (ack && pend > 0) pend--;
            m_ack_i   = ack;
            m_stall_i = rand_stall ? 1'($urandom_range(0, 1)) : stall_force;
        end
    end

    task automatic wb_req(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input logic we);
        bit          done = 0;
        logic [31:0] off;
        s_addr_i = addr;
        s_data_i = data;
        s_sel_i  = sel;
        s_we_i   = we;
        s_stb_i  = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk_i);
            if (!s_stall_o) begin
                done = 1;
                if (we) begin
                    off = addr & RING_MASK;
                    exp_q.push_back({BASE + off, data, sel});
                    if (off < m_prev_off && m_wraps != 16'hFFFF) m_wraps++;
                    m_prev_off = off;
                end
            end
            @(posedge clk_i);
            #2;
        end
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        if (!done) check("accept_timeout", 68'd0, 68'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_i);
            if (idle_o) ok = 1;
        end
        check(tag, 68'(ok), 68'd1);
        @(posedge clk_i);
        #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    initial begin
        int base;
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset state
        cycles(3);
        @(negedge clk_i);
        check("rst_stall", 68'(s_stall_o), 68'd0);
        check("rst_ack", 68'(s_ack_o), 68'd0);
        check("rst_stb", 68'(m_stb_o), 68'd0);
        check("rst_we", 68'(m_we_o), 68'd0);
        check("rst_level", 68'(level_o), 68'd0);
        check("rst_idle", 68'(idle_o), 68'd1);
        check("rst_wraps", 68'(wraps_o), 68'd0);
        check("rst_read_seen", 68'(read_seen_o), 68'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        cycles(1);

        // Single write with address translation
        auto_ack = 1;
        wb_req(32'h0000_4010, 32'hA5A5_A5A5, 4'hF, 1'b1);
        @(negedge clk_i);
        check("single_ack", 68'(s_ack_o), 68'd1);
        check("single_stb", 68'(m_stb_o), 68'd1);
        check("single_addr", 68'(m_addr_o), 68'h0010);
        wait_idle("single_idle");

        // Full FIFO under downstream stall
        stall_force = 1;
        cycles(2);
        for (int i = 0; i < 4; i++)
            wb_req(32'h100 + 32'(i * 4), $urandom, 4'(i + 1), 1'b1);
        s_addr_i = 32'h200;
        s_data_i = 32'hDEAD_BEEF;
        s_we_i   = 1'b1;
        s_stb_i  = 1'b1;
        @(negedge clk_i);
        check("full_stall", 68'(s_stall_o), 68'd1);
        check("full_level", 68'(level_o), 68'd4);
        check("full_head_hold", 68'(m_addr_o), 68'(exp_q[0][67:36]));
        @(posedge clk_i);
        #2;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        stall_force = 0;
        wait_idle("full_drain_idle");
        check("full_queue_empty", 68'(exp_q.size()), 68'd0);

        // Outstanding limit
        auto_ack = 0;
        base = strobes;
        for (int i = 0; i < 4; i++)
            wb_req(32'h300 + 32'(i * 4), $urandom, 4'hF, 1'b1);
        repeat (4) @(negedge clk_i);
        check("outst_strobes", 68'(strobes - base), 68'd2);
        check("outst_stb_low", 68'(m_stb_o), 68'd0);
        check("outst_level", 68'(level_o), 68'd2);
        @(posedge clk_i);
        #2;
        stray_ack = 1;
        @(posedge clk_i);
        #2;
        stray_ack = 0;
        repeat (3) @(negedge clk_i);
        check("outst_one_more", 68'(strobes - base), 68'd3);
        check("outst_level1", 68'(level_o), 68'd1);
        @(posedge clk_i);
        #2;
        auto_ack = 1;
        wait_idle("outst_idle");

        // Ring wrap and upstream read
        check("wrap_before", 68'(wraps_o), 68'(m_wraps));
        wb_req(32'h0000_3FFC, 32'h1111_2222, 4'h3, 1'b1);
        wb_req(32'h0000_0000, 32'h3333_4444, 4'hC, 1'b1);
        @(negedge clk_i);
        check("wrap_model", 68'(wraps_o), 68'(m_wraps));
        check("wrap_one", 68'(wraps_o), 68'd1);
        @(posedge clk_i);
        #2;
        wait_idle("wrap_idle");
        base = strobes;
        wb_req(32'h0000_0040, 32'h0, 4'hF, 1'b0);
        @(negedge clk_i);
        check("read_ack", 68'(s_ack_o), 68'd1);
        check("read_no_stb", 68'(m_stb_o), 68'd0);
        check("read_seen", 68'(read_seen_o), 68'd1);
        repeat (3) @(negedge clk_i);
        check("read_no_write", 68'(strobes - base), 68'd0);
        @(posedge clk_i);
        #2;

        // Reset mid-operation
        auto_ack = 0;
        wb_req(32'h500, $urandom, 4'hF, 1'b1);
        cycles(2);
        stall_force = 1;
        cycles(2);
        for (int i = 0; i < 3; i++)
            wb_req(32'h600 + 32'(i * 4), $urandom, 4'hF, 1'b1);
        @(negedge clk_i);
        check("pre_rst_level", 68'(level_o), 68'd3);
        check("pre_rst_busy", 68'(idle_o), 68'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        exp_q.delete();
        flush = 1;
        m_prev_off = '0;
        m_wraps = '0;
        stall_force = 0;
        @(negedge clk_i);
        check("mid_rst_level", 68'(level_o), 68'd0);
        check("mid_rst_idle", 68'(idle_o), 68'd1);
        check("mid_rst_stb", 68'(m_stb_o), 68'd0);
        check("mid_rst_read_seen", 68'(read_seen_o), 68'd0);
        @(posedge clk_i);
        #2;
        stray_ack = 1;
        @(posedge clk_i);
        #2;
        stray_ack = 0;
        repeat (2) @(negedge clk_i);
        check("stray_idle", 68'(idle_o), 68'd1);
        check("stray_level", 68'(level_o), 68'd0);
        @(posedge clk_i);
        #2;
        auto_ack = 1;
        wb_req(32'h0000_4444, 32'hCAFE_F00D, 4'h5, 1'b1);
        wait_idle("post_rst_idle");

        // Random traffic with random downstream stall
        rand_stall = 1;
        for (int i = 0; i < 32; i++) begin
            logic we;
            we = ($urandom_range(0, 7) != 0);
            wb_req($urandom, $urandom, 4'($urandom_range(0, 15)), we);
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end
        rand_stall = 0;
        wait_idle("rand_idle");
        check("rand_queue_empty", 68'(exp_q.size()), 68'd0);
        check("rand_wraps", 68'(wraps_o), 68'(m_wraps));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
